frac_tick_gen: RTL and testbench
================================

# frac_tick_gen

Multi-channel fractional tick generator, the parametrised successor to the single fixed 1 Hz divider. Each channel runs a modulo phase accumulator and emits a one-cycle `tick` at the average rate f_clk·STEP/MOD, plus a 50%-duty square wave. STEP and MOD are runtime-programmable per channel through a valid/ready config port. It sits beside the top-level logic and feeds display refresh, debounce and blink timing.

## Interface
- `NCH`, 4: number of independent channels (1..16).
- `ACC_W`, 32: accumulator, STEP and MOD width.
- `RST_STEP`, 1: per-channel STEP after reset.
- `RST_MOD`, 50_000_000: per-channel MOD after reset (1 Hz tick at 50 MHz).

- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  NCH  per-channel run enable.
- `sync`  in  1  realign all channels (clear phase).
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config port can accept.
- `cfg_ch`  in  max(1,$clog2(NCH))  target channel.
- `cfg_step`  in  ACC_W  new STEP.
- `cfg_mod`  in  ACC_W  new MOD.
- `cfg_err`  out  1  one-cycle pulse: request rejected.
- `tick`  out  NCH  one-cycle pulse per wrap.
- `sq`  out  NCH  square wave; toggles on every tick.

## Operation
- State per channel: `acc`, `step`, `mod`, `sq`.
- Reset values: acc=0, step=RST_STEP, mod=RST_MOD, tick=0, sq=0, cfg_ready=1, cfg_err=0.
- Each cycle with en[i]=1, compute sum = acc + step at ACC_W+1 bits, so the add cannot overflow.
  - If sum ≥ mod: acc ← sum − mod, tick[i] ← 1, sq[i] ← ~sq[i].
  - Otherwise: acc ← sum, tick[i] ← 0.
- en[i]=0: acc and sq hold, tick[i]=0.
- Invariant acc < mod guarantees at most one tick per cycle.
- Config accept: cfg_valid & cfg_ready. The request is legal iff mod ≠ 0 and step < mod; step=0 is legal and means the channel never ticks.
  - Legal: the channel's step and mod are loaded, acc and sq are cleared, and tick is 0 on that edge.
  - Illegal: nothing changes and cfg_err pulses for 1 cycle.
  - After any accept, cfg_ready is 0 for exactly 1 cycle, then returns to 1.
  - cfg_valid while cfg_ready=0 is ignored. The requester holds it until accepted.
  - cfg_ch ≥ NCH is treated as illegal (cfg_err).
- `sync`=1: every channel's acc and sq are cleared and all ticks are 0. Step and mod are unchanged.
- sync and a legal accept on the same edge: the config is stored and everything is cleared. The net result equals accept-then-sync.
- rst overrides everything, including in the middle of a config accept or while sync is asserted.

## Timing
- All outputs are registered. tick and the wrapped acc take effect on the same edge. tick is visible for exactly one cycle after that edge.
- First tick after reset, sync or config, with en held at 1: ceil(mod/step) cycles later.
- A config accept takes effect on the accepting edge. The next accept is possible 2 cycles after the previous one.
- cfg_err is asserted the cycle after the accepting edge, the same cycle in which cfg_ready is 0.
- There are no combinational paths from inputs to outputs.

## Structure
- Package `frac_tick_pkg` holds the default constants (RST_STEP, RST_MOD, ACC_W default) and the `chan_cfg_t` struct {step, mod}.
- Sub-module `frac_div_chan` holds one channel's accumulator, compare/subtract, tick and sq logic, with inputs en, clr, load, step, mod. It is instantiated NCH times with generate.
- The top level holds the config handshake FSM (READY → BUSY → READY), the legality check and channel decode.

## Test plan
- Reset, NCH=2, RST_STEP=1, RST_MOD=5, en=2'b01 → tick[0] every 5th cycle, sq[0] period 10 cycles, tick[1]=0 and sq[1]=0 throughout.
- Config ch0 step=3, mod=8, then en[0]=1 → acc sequence 3,6,1,4,7,2,5,0 with ticks at acc 1, 2 and 0, i.e. 3 ticks per 8 cycles, repeating exactly.
- Requests mod=0, step=8/mod=8, and cfg_ch=NCH → cfg_err pulses 1 cycle each, channel state unchanged, cfg_ready low 1 cycle after each.
- Back-to-back: cfg_valid held for 2 requests → 2nd accepted exactly 2 cycles after the 1st, and only because cfg_ready dropped for 1 cycle in between.
- sync mid-run with step=1, mod=5, acc=3 → acc=0, sq=0, and the next tick 5 cycles after sync deasserts. Sync plus a legal accept on the same edge → new config active, all phases cleared.
- ACC_W=8, mod=255, step=254 → no overflow. acc sequence 254,253,252… with a tick every cycle after the first. en dropped for 3 cycles → acc and sq frozen, no ticks.

Source files
------------

// File: rtl/frac_tick_pkg.sv
// Shared constants, per-channel configuration record and the config legality rule
// for the fractional tick generator.
package frac_tick_pkg;

    localparam int DEF_ACC_W = 32;
    localparam int MAX_ACC_W = 64;
    localparam logic [DEF_ACC_W-1:0] DEF_RST_STEP = 32'd1;
    localparam logic [DEF_ACC_W-1:0] DEF_RST_MOD  = 32'd50_000_000;

    // Fields are sized for the widest supported accumulator; narrower ones zero-extend.
    typedef struct packed {
        logic [MAX_ACC_W-1:0] step;
        logic [MAX_ACC_W-1:0] mod;
    } chan_cfg_t;

    function automatic logic cfgIsLegal(input chan_cfg_t c);
        return (c.mod != '0) && (c.step < c.mod);
    endfunction

endpackage

// File: rtl/frac_div_chan.sv
// One channel: modulo phase accumulator producing a wrap tick and a toggling square wave.
module frac_div_chan
    import frac_tick_pkg::*;
#(
    parameter int                ACC_W    = DEF_ACC_W,
    parameter logic [ACC_W-1:0]  RST_STEP = ACC_W'(DEF_RST_STEP),
    parameter logic [ACC_W-1:0]  RST_MOD  = ACC_W'(DEF_RST_MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [ACC_W-1:0] loadStep,
    input  logic [ACC_W-1:0] loadMod,
    output logic             tick,
    output logic             sq
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] mod;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   wrapped;

    // One extra bit keeps acc + step exact for any step < mod.
    assign sum     = {1'b0, acc} + {1'b0, step};
    assign wrapped = sum - {1'b0, mod};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            step <= RST_STEP;
            mod  <= RST_MOD;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (load) begin
            step <= loadStep;
            mod  <= loadMod;
            acc  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (clr) begin
            acc  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (en) begin
            if (sum >= {1'b0, mod}) begin
                acc  <= wrapped[ACC_W-1:0];
                tick <= 1'b1;
                sq   <= ~sq;
            end else begin
                acc  <= sum[ACC_W-1:0];
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/frac_tick_gen.sv
// Multi-channel fractional tick generator: config handshake, legality check,
// channel decode and NCH accumulator channels.
module frac_tick_gen
    import frac_tick_pkg::*;
#(
    parameter int               NCH      = 4,
    parameter int               ACC_W    = DEF_ACC_W,
    parameter logic [ACC_W-1:0] RST_STEP = ACC_W'(DEF_RST_STEP),
    parameter logic [ACC_W-1:0] RST_MOD  = ACC_W'(DEF_RST_MOD)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NCH-1:0]                              en,
    input  logic                                        sync,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]    cfg_ch,
    input  logic [ACC_W-1:0]                            cfg_step,
    input  logic [ACC_W-1:0]                            cfg_mod,
    output logic                                        cfg_err,
    output logic [NCH-1:0]                              tick,
    output logic [NCH-1:0]                              sq
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;

    logic [0:0] state;
    chan_cfg_t  reqCfg;
    logic       chIsValid;
    logic       accept;
    logic       legal;

    always_comb begin
        reqCfg      = '0;
        reqCfg.step = MAX_ACC_W'(cfg_step);
        reqCfg.mod  = MAX_ACC_W'(cfg_mod);
    end

    assign chIsValid = ({1'b0, cfg_ch} < (CH_W+1)'(NCH));
    assign cfg_ready = (state == ST_READY);
    assign accept    = cfg_valid & cfg_ready;
    assign legal     = chIsValid & cfgIsLegal(reqCfg);

    // Every accept, legal or not, costs one BUSY cycle before the next can land.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_READY;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & ~legal;
            case (state)
                ST_READY: state <= accept ? ST_BUSY : ST_READY;
                default:  state <= ST_READY;
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : gChan
        logic loadCh;
        assign loadCh = accept & legal & (cfg_ch == CH_W'(i));

        frac_div_chan #(
            .ACC_W    (ACC_W),
            .RST_STEP (RST_STEP),
            .RST_MOD  (RST_MOD)
        ) uChan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .clr      (sync),
            .load     (loadCh),
            .loadStep (cfg_step),
            .loadMod  (cfg_mod),
            .tick     (tick[i]),
            .sq       (sq[i])
        );
    end

endmodule

// File: tb/tb_frac_tick_gen.sv
// Directed bench for frac_tick_gen: 3 channels, 8-bit accumulators, reset config 1/5.
module tb_frac_tick_gen;

    logic       clk;
    logic       rst;
    logic [2:0] en;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_step;
    logic [7:0] cfg_mod;
    logic       cfg_err;
    logic [2:0] tick;
    logic [2:0] sq;

    int nAssert = 0;
    int nFail   = 0;

    frac_tick_gen #(
        .NCH      (3),
        .ACC_W    (8),
        .RST_STEP (8'd1),
        .RST_MOD  (8'd5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_step  (cfg_step),
        .cfg_mod   (cfg_mod),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .sq        (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic       expTick;
    logic       expTick1;
    logic       expSq;
    logic       expSq1;
    logic [7:0] pat38;
    logic [4:0] pat25;
    logic [1:0] badCh   [3];
    logic [7:0] badStep [3];
    logic [7:0] badMod  [3];

    initial begin
        rst = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_step = '0; cfg_mod = '0;
        cyc(); cyc();
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_sq", 32'(sq), 32'h0);
        chk("reset_ready", 32'(cfg_ready), 32'h1);
        chk("reset_err", 32'(cfg_err), 32'h0);

        // Default step=1/mod=5 on ch0 only
        rst = 1'b0; en = 3'b001; expSq = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            expTick = (k % 5 == 0);
            expSq   = expSq ^ expTick;
            chk($sformatf("dflt_tick0_k%0d", k), 32'(tick[0]), 32'(expTick));
            chk($sformatf("dflt_sq0_k%0d", k), 32'(sq[0]), 32'(expSq));
            chk($sformatf("dflt_idle12_k%0d", k), 32'({tick[2:1], sq[2:1]}), 32'h0);
        end

        // step=3 mod=8: ticks on the 3rd, 6th and 8th cycle of each 8
        pat38 = 8'b1010_0100;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_step = 8'd3; cfg_mod = 8'd8;
        cyc();
        cfg_valid = 1'b0;
        chk("cfg38_ready", 32'(cfg_ready), 32'h0);
        chk("cfg38_err", 32'(cfg_err), 32'h0);
        chk("cfg38_tick", 32'(tick), 32'h0);
        chk("cfg38_sq0", 32'(sq[0]), 32'h0);
        expSq = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 1) chk("cfg38_ready_back", 32'(cfg_ready), 32'h1);
            expTick = pat38[(k-1) % 8];
            expSq   = expSq ^ expTick;
            chk($sformatf("run38_tick0_k%0d", k), 32'(tick[0]), 32'(expTick));
            chk($sformatf("run38_sq0_k%0d", k), 32'(sq[0]), 32'(expSq));
        end

        // Illegal requests leave ch0 untouched
        en = 3'b000;
        badCh[0] = 2'd0; badStep[0] = 8'd1; badMod[0] = 8'd0;
        badCh[1] = 2'd0; badStep[1] = 8'd8; badMod[1] = 8'd8;
        badCh[2] = 2'd3; badStep[2] = 8'd1; badMod[2] = 8'd5;
        for (int r = 0; r < 3; r++) begin
            cfg_valid = 1'b1; cfg_ch = badCh[r]; cfg_step = badStep[r]; cfg_mod = badMod[r];
            cyc();
            cfg_valid = 1'b0;
            chk($sformatf("bad%0d_err", r), 32'(cfg_err), 32'h1);
            chk($sformatf("bad%0d_ready", r), 32'(cfg_ready), 32'h0);
            chk($sformatf("bad%0d_sq0", r), 32'(sq[0]), 32'(expSq));
            cyc();
            chk($sformatf("bad%0d_err_clr", r), 32'(cfg_err), 32'h0);
            chk($sformatf("bad%0d_ready_back", r), 32'(cfg_ready), 32'h1);
        end
        en = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            expTick = pat38[k-1];
            expSq   = expSq ^ expTick;
            chk($sformatf("kept38_tick0_k%0d", k), 32'(tick[0]), 32'(expTick));
            chk($sformatf("kept38_sq0_k%0d", k), 32'(sq[0]), 32'(expSq));
        end

        // Back-to-back: legal ch1 2/5, then illegal request held through the BUSY cycle
        en = 3'b000;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_step = 8'd2; cfg_mod = 8'd5;
        cyc();
        chk("b2b_first_ready", 32'(cfg_ready), 32'h0);
        chk("b2b_first_err", 32'(cfg_err), 32'h0);
        cfg_ch = 2'd0; cfg_step = 8'd1; cfg_mod = 8'd0;
        cyc();
        chk("b2b_hold_ready", 32'(cfg_ready), 32'h1);
        chk("b2b_hold_err", 32'(cfg_err), 32'h0);
        cyc();
        cfg_valid = 1'b0;
        chk("b2b_second_ready", 32'(cfg_ready), 32'h0);
        chk("b2b_second_err", 32'(cfg_err), 32'h1);
        cyc();
        chk("b2b_done_ready", 32'(cfg_ready), 32'h1);
        chk("b2b_done_err", 32'(cfg_err), 32'h0);

        // ch1 at 2/5: acc 2,4,1,3,0 -> ticks on 3rd and 5th
        pat25 = 5'b10100;
        en = 3'b010; expSq1 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            expTick1 = pat25[(k-1) % 5];
            expSq1   = expSq1 ^ expTick1;
            chk($sformatf("ch1_tick_k%0d", k), 32'(tick), 32'({1'b0, expTick1, 1'b0}));
            chk($sformatf("ch1_sq_k%0d", k), 32'(sq[1]), 32'(expSq1));
        end

        // sync mid-run at acc=3 with sq=1
        en = 3'b000;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_step = 8'd1; cfg_mod = 8'd5;
        cyc();
        cfg_valid = 1'b0;
        cyc();
        en = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("presync_tick0_k%0d", k), 32'(tick[0]), 32'(k == 5));
        end
        chk("presync_sq0", 32'(sq[0]), 32'h1);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("sync_tick", 32'(tick), 32'h0);
        chk("sync_sq", 32'(sq), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("postsync_tick0_k%0d", k), 32'(tick[0]), 32'(k == 5));
        end
        chk("postsync_sq0", 32'(sq[0]), 32'h1);

        // sync and legal accept on one edge: ch0 becomes 2/7, all phases cleared
        en = 3'b011;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_step = 8'd2; cfg_mod = 8'd7; sync = 1'b1;
        cyc();
        cfg_valid = 1'b0; sync = 1'b0;
        chk("syncacc_tick", 32'(tick), 32'h0);
        chk("syncacc_sq", 32'(sq), 32'h0);
        chk("syncacc_ready", 32'(cfg_ready), 32'h0);
        chk("syncacc_err", 32'(cfg_err), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("syncacc_tick_k%0d", k), 32'(tick), 32'({1'b0, k == 3, k == 4}));
        end

        // Near-full 8-bit range: step=254 mod=255
        en = 3'b000;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_step = 8'd254; cfg_mod = 8'd255;
        cyc();
        cfg_valid = 1'b0;
        chk("wide_err", 32'(cfg_err), 32'h0);
        cyc();
        en = 3'b001; expSq = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            expTick = (k >= 2);
            expSq   = expSq ^ expTick;
            chk($sformatf("wide_tick0_k%0d", k), 32'(tick[0]), 32'(expTick));
            chk($sformatf("wide_sq0_k%0d", k), 32'(sq[0]), 32'(expSq));
        end
        en = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("frozen_tick_k%0d", k), 32'(tick), 32'h0);
            chk($sformatf("frozen_sq0_k%0d", k), 32'(sq[0]), 32'(expSq));
        end
        en = 3'b001;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            expSq = ~expSq;
            chk($sformatf("resume_tick0_k%0d", k), 32'(tick[0]), 32'h1);
            chk($sformatf("resume_sq0_k%0d", k), 32'(sq[0]), 32'(expSq));
        end

        // Reset during a config accept: defaults win, request discarded
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_step = 8'd2; cfg_mod = 8'd3; rst = 1'b1;
        cyc();
        cfg_valid = 1'b0; rst = 1'b0;
        chk("rstacc_ready", 32'(cfg_ready), 32'h1);
        chk("rstacc_err", 32'(cfg_err), 32'h0);
        chk("rstacc_tick", 32'(tick), 32'h0);
        chk("rstacc_sq", 32'(sq), 32'h0);
        en = 3'b011;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("rstacc_run_k%0d", k), 32'(tick), 32'({1'b0, k == 5, k == 5}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
